// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam int          PC_INCREMENT      = 4;

endpackage

// File: rtl/program_counter.sv
// Program counter: holds the fetch PC and picks the sequential or branch successor.
// A misaligned branch target falls through to pc+4 and sets a sticky fault.
module program_counter
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_update,
    input  logic                  i_branch_taken,
    input  logic [ADDR_WIDTH-1:0] i_branch_target,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic                  o_misalign_fault
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_misalign;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic                  w_target_aligned;

    // Modulo adder: the top of the address space wraps to zero silently.
    assign w_pc_plus4       = r_pc + ADDR_WIDTH'(PC_INCREMENT);
    assign w_target_aligned = (i_branch_target[1:0] == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else if (i_update) begin
            if (i_branch_taken && w_target_aligned) begin
                r_pc <= i_branch_target;
            end else begin
                r_pc <= w_pc_plus4;
            end
            if (i_branch_taken && !w_target_aligned) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign o_pc             = r_pc;
    assign o_pc_plus4       = w_pc_plus4;
    assign o_misalign_fault = r_misalign;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues one instruction read per pipeline round and holds the result
// in the instruction register for decode.
//
//   state    | meaning
//   ST_IDLE  | no read outstanding; a request strobe issues one
//   ST_WAIT  | read outstanding; first valid is captured, receive without valid is a miss
//   ST_DRAIN | after a miss; swallows the one late response
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_RequestState,
    input  logic                  fetch_ReceiveState,
    input  logic                  writebackState,
    input  logic                  branchTaken,
    input  logic [ADDR_WIDTH-1:0] branchTarget,
    output logic                  memReadEnable,
    output logic [ADDR_WIDTH-1:0] memAddress,
    input  logic [DATA_WIDTH-1:0] memReadData,
    input  logic                  memReadValid,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instructionValid,
    output logic [ADDR_WIDTH-1:0] pcCurrent,
    output logic [ADDR_WIDTH-1:0] pcPlus4,
    output logic                  fetchMiss,
    output logic                  misalignFault
);

    fetch_state_e          r_state;
    fetch_state_e          w_next_state;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_instr_valid;
    logic                  r_fetch_miss;
    logic                  w_read_en;
    logic                  w_capture;
    logic                  w_miss_load;
    logic [ADDR_WIDTH-1:0] w_pc;

    program_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk              (clk),
        .reset            (reset),
        .i_update         (writebackState),
        .i_branch_taken   (branchTaken),
        .i_branch_target  (branchTarget),
        .o_pc             (w_pc),
        .o_pc_plus4       (pcPlus4),
        .o_misalign_fault (misalignFault)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A request in any state restarts the read at the current PC and outranks receive.
    always_comb begin
        w_next_state = r_state;
        w_read_en    = 1'b0;
        w_capture    = 1'b0;
        w_miss_load  = 1'b0;
        if (fetch_RequestState) begin
            w_read_en = 1'b1;
            if (r_state == ST_IDLE && memReadValid) begin
                w_capture    = 1'b1;
                w_next_state = ST_IDLE;
            end else begin
                w_next_state = ST_WAIT;
            end
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (memReadValid) begin
                        w_capture    = 1'b1;
                        w_next_state = ST_IDLE;
                    end else if (fetch_ReceiveState) begin
                        w_miss_load  = 1'b1;
                        w_next_state = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (memReadValid) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_fetch_miss  <= 1'b0;
        end else begin
            r_fetch_miss <= w_miss_load;
            if (w_capture) begin
                r_instr       <= memReadData;
                r_instr_valid <= 1'b1;
            end else if (w_miss_load) begin
                r_instr       <= NOP_INSTR;
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign memReadEnable    = w_read_en & ~reset;
    assign memAddress       = w_pc;
    assign pcCurrent        = w_pc;
    assign instruction      = r_instr;
    assign instructionValid = r_instr_valid;
    assign fetchMiss        = r_fetch_miss;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: table of pipeline rounds plus
// a hand-written mid-fetch async reset sequence.
module tb_instruction_fetch_unit;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic          req, recv, wb, br;
    logic [AW-1:0] tgt;
    logic          mre;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdata;
    logic          mvalid;
    logic [DW-1:0] instr;
    logic          ivalid;
    logic [AW-1:0] pc, pc4;
    logic          miss, mis;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk                (clk),
        .reset              (reset),
        .fetch_RequestState (req),
        .fetch_ReceiveState (recv),
        .writebackState     (wb),
        .branchTaken        (br),
        .branchTarget       (tgt),
        .memReadEnable      (mre),
        .memAddress         (maddr),
        .memReadData        (mdata),
        .memReadValid       (mvalid),
        .instruction        (instr),
        .instructionValid   (ivalid),
        .pcCurrent          (pc),
        .pcPlus4            (pc4),
        .fetchMiss          (miss),
        .misalignFault      (mis)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [DW-1:0] instr;
        logic          valid;
    } exp_t;
    exp_t sb[$];

    // mode: 0 = data one cycle after request, 1 = zero latency, 2 = miss with late data
    typedef struct {
        int            mode;
        logic          br;
        logic [AW-1:0] tgt;
    } vec_t;
    vec_t vecs[10];

    logic [AW-1:0] m_pc;
    logic          m_mis;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {a[29:0], 2'b11};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic round(input vec_t v);
        exp_t          e;
        logic [AW-1:0] p4;
        req = 1'b1;
        if (v.mode == 1) begin
            mvalid = 1'b1;
            mdata  = mem_word(m_pc);
        end
        #1;
        chk("req_enable", mre, 1);
        chk("req_addr", maddr, m_pc);
        e.instr = (v.mode == 2) ? NOP : mem_word(m_pc);
        e.valid = (v.mode != 2);
        sb.push_back(e);
        next_cycle();
        req    = 1'b0;
        mvalid = 1'b0;
        if (v.mode == 1) begin
            chk("zero_lat_instr", instr, mem_word(m_pc));
            chk("zero_lat_valid", ivalid, 1);
        end
        recv = 1'b1;
        if (v.mode == 0) begin
            mvalid = 1'b1;
            mdata  = mem_word(m_pc);
        end
        #1;
        chk("recv_no_enable", mre, 0);
        next_cycle();
        recv   = 1'b0;
        mvalid = 1'b0;
        e = sb.pop_front();
        chk("instr", instr, e.instr);
        chk("instr_valid", ivalid, e.valid);
        chk("miss_pulse", miss, (v.mode == 2));
        next_cycle();
        chk("miss_once", miss, 0);
        if (v.mode == 2) begin
            mvalid = 1'b1;
            mdata  = 32'hDEAD_BEEF;
        end
        next_cycle();
        mvalid = 1'b0;
        chk("instr_hold", instr, e.instr);
        chk("valid_hold", ivalid, e.valid);
        wb  = 1'b1;
        br  = v.br;
        tgt = v.tgt;
        next_cycle();
        wb = 1'b0;
        br = 1'b0;
        if (v.br && v.tgt[1:0] == 2'b00) m_pc = v.tgt;
        else m_pc = m_pc + 32'd4;
        if (v.br && v.tgt[1:0] != 2'b00) m_mis = 1'b1;
        p4 = m_pc + 32'd4;
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc4, p4);
        chk("misalign", mis, m_mis);
    endtask

    initial begin
        reset = 1'b1; req = 0; recv = 0; wb = 0; br = 0; tgt = '0;
        mdata = '0; mvalid = 0;
        m_pc = '0; m_mis = 1'b0;

        vecs[0] = '{0, 1'b0, 32'h0};
        vecs[1] = '{0, 1'b0, 32'h0};
        vecs[2] = '{2, 1'b0, 32'h0};
        vecs[3] = '{0, 1'b1, 32'h0000_0100};
        vecs[4] = '{1, 1'b0, 32'h0};
        vecs[5] = '{1, 1'b1, 32'h0000_0020};
        vecs[6] = '{0, 1'b1, 32'h0000_0102};
        vecs[7] = '{0, 1'b1, 32'hFFFF_FFFC};
        vecs[8] = '{0, 1'b0, 32'h0};
        vecs[9] = '{0, 1'b0, 32'h0};

        repeat (2) @(negedge clk);
        chk("rst_instr", instr, NOP);
        chk("rst_valid", ivalid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_miss", miss, 0);
        chk("rst_misalign", mis, 0);
        reset = 1'b0;
        next_cycle();

        foreach (vecs[i]) round(vecs[i]);

        // Async reset while a read is outstanding; request held high to check gating.
        req = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_instr", instr, NOP);
        chk("mid_rst_valid", ivalid, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_misalign", mis, 0);
        chk("mid_rst_miss", miss, 0);
        chk("mid_rst_no_enable", mre, 0);
        @(negedge clk);
        req = 1'b0;
        next_cycle();
        reset = 1'b0;
        m_pc  = '0;
        m_mis = 1'b0;
        next_cycle();
        round(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
